// File: rtl/alu32_arbiter_if.sv
// ============================================================================
//  Module      : alu32_arbiter_if
//  Description : Bundle of the two requester channels and the response
//                channel of the shared-ALU arbiter.
//                slave  - arbiter side (consumes requests, produces responses)
//                master - issue-logic / consumer side
//  Signals     : req{0,1}_valid/ready/a/b/op, rsp_valid/ready/id/result/cnzv
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu32_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_cnzv;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cnzv
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cnzv
    );
endinterface

`default_nettype wire

// File: rtl/alu32_arbiter.sv
// ============================================================================
//  Module      : alu32_arbiter (plus the combinational alu32 it shares)
//  Description : Shares one combinational alu32 between two requesters.
//                Round-robin (or fixed req0 priority) grant in IDLE, operands
//                latched on the handshake, ALU output registered in EXEC,
//                response held in RESP until the consumer takes it.
//  Ports       : clk      - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - alu32_arbiter_if.slave (requests + response)
//                busy     - high whenever the FSM is not IDLE
//  Parameters  : FIXED_PRIO - 1: req0 wins simultaneous requests,
//                             0: round-robin against the last grant
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// alu32: opcode map
//   000 AND  001 OR  010 XOR  011 NOR  100 SLL  101 SRL  110 ADD  111 SUB
// c is the carry out of the 33-bit add; for SUB this is a + ~b + 1, so c=1
// means "no borrow". v is signed overflow for ADD/SUB, 0 otherwise.
// ----------------------------------------------------------------------------
module alu32 (
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    input  wire logic [2:0]  op,
    output logic      [31:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);
    logic [32:0] w_sum;

    always_comb begin
        w_sum  = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: result = a ^ b;
            3'b011: result = ~(a | b);
            3'b100: result = a << b[4:0];
            3'b101: result = a >> b[4:0];
            3'b110: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[31:0];
                c      = w_sum[32];
                v      = (a[31] == b[31]) && (result[31] != a[31]);
            end
            default: begin
                w_sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result = w_sum[31:0];
                c      = w_sum[32];
                v      = (a[31] != b[31]) && (result[31] != a[31]);
            end
        endcase
        n = result[31];
        z = (result == 32'd0);
    end
endmodule

module alu32_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    alu32_arbiter_if.slave    bus,
    output logic              busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        id_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_cnzv_q;

    logic        w_grant_valid;
    logic        w_grant_id;
    logic        w_take;
    logic        w_load_rsp;
    logic        w_rsp_done;
    logic [31:0] w_alu_result;
    logic        w_c, w_n, w_z, w_v;

    // ------------------------------------------------------------------
    // Grant selection. Only meaningful in IDLE; ready is gated by state.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_valid = bus.req0_valid | bus.req1_valid;
        w_grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else if (bus.req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    assign bus.req0_ready = (state_q == S_IDLE) & w_grant_valid & ~w_grant_id;
    assign bus.req1_ready = (state_q == S_IDLE) & w_grant_valid &  w_grant_id;

    assign w_take     = (state_q == S_IDLE) & w_grant_valid;
    assign w_load_rsp = (state_q == S_EXEC);
    assign w_rsp_done = (state_q == S_RESP) & rsp_valid_q & bus.rsp_ready;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_grant_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (w_rsp_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand latch on the request handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (w_take) begin
            a_q          <= w_grant_id ? bus.req1_a  : bus.req0_a;
            b_q          <= w_grant_id ? bus.req1_b  : bus.req0_b;
            op_q         <= w_grant_id ? bus.req1_op : bus.req0_op;
            id_q         <= w_grant_id;
            last_grant_q <= w_grant_id;
        end
    end

    alu32 u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (w_alu_result),
        .c      (w_c),
        .n      (w_n),
        .z      (w_z),
        .v      (w_v)
    );

    // ------------------------------------------------------------------
    // Response registers. Result/flags only change on the EXEC edge, so
    // they keep their value after the consumer takes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_cnzv_q   <= '0;
        end else if (w_load_rsp) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= w_alu_result;
            rsp_cnzv_q   <= {w_c, w_n, w_z, w_v};
        end else if (w_rsp_done) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cnzv   = rsp_cnzv_q;
    assign busy           = (state_q != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
// ============================================================================
//  Module      : tb_alu32_arbiter
//  Description : Scoreboard bench for alu32_arbiter. Stimulus pushes the
//                expected response (id, result, cnzv) into a queue before
//                issuing; a monitor pops on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu32_arbiter;
    localparam logic [2:0] c_ADD = 3'b110;
    localparam logic [2:0] c_SUB = 3'b111;
    localparam int         c_LIMIT = 60;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [3:0]  cnzv;
    } exp_t;

    logic clk;
    logic reset_n;
    logic busy, busy_fp;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    alu32_arbiter_if bus ();
    alu32_arbiter_if bus_fp ();

    alu32_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    alu32_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_fp),
        .busy    (busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: ADD/SUB only, overflow from 64-bit signed math.
    function automatic exp_t ref_op(input logic id, input logic [31:0] a,
                                    input logic [31:0] b, input logic [2:0] op);
        exp_t   e;
        longint d;
        logic   c, v;
        logic [31:0] r;
        if (op == c_ADD) begin
            r = a + b;
            c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
            d = longint'($signed(a)) + longint'($signed(b));
        end else begin
            r = a - b;
            c = (a >= b);
            d = longint'($signed(a)) - longint'($signed(b));
        end
        v      = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        e.id   = id;
        e.res  = r;
        e.cnzv = {c, r[31], (r == 32'd0), v};
        return e;
    endfunction

    function automatic exp_t mk(input logic id, input logic [31:0] r, input logic [3:0] f);
        exp_t e;
        e.id = id; e.res = r; e.cnzv = f;
        return e;
    endfunction

    // Presents one operation on requester id and returns one ns after the
    // accepting clock edge, with valid already dropped.
    task automatic req_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        if (id == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
        for (int n = 0; n < c_LIMIT && !acc; n++) begin
            #1;
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
                acc = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout id=%0d: got no ready expected ready within %0d cycles", id, c_LIMIT);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id=%0d res=%h cnzv=%b expected none",
                             bus.rsp_id, bus.rsp_result, bus.rsp_cnzv);
                end else begin
                    e = q.pop_front();
                    chk("rsp", {27'd0, bus.rsp_id, bus.rsp_result, bus.rsp_cnzv},
                               {27'd0, e.id, e.res, e.cnzv});
                end
            end
        end
    end

    initial begin
        logic [36:0] snap;
        bit          seen;
        int          got;
        logic        rid;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp_ready  = 1'b1;
        bus_fp.req0_valid = 0; bus_fp.req0_a = 0; bus_fp.req0_b = 0; bus_fp.req0_op = 0;
        bus_fp.req1_valid = 0; bus_fp.req1_a = 0; bus_fp.req1_b = 0; bus_fp.req1_op = 0;
        bus_fp.rsp_ready  = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        chk("reset_rsp_id",     64'(bus.rsp_id),     64'd0);
        chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("reset_rsp_cnzv",   64'(bus.rsp_cnzv),   64'd0);
        chk("reset_busy",       64'(busy),           64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-EXEC discards the operation
        req_op(1'b0, 32'd9, 32'd9, c_ADD);
        chk("exec_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midreset_busy",      64'(busy),          64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'd0);

        // Single ADD with latency check
        q.push_back(mk(1'b0, 32'h0000_0003, 4'b0000));
        req_op(1'b0, 32'h0000_0001, 32'h0000_0002, c_ADD);
        chk("lat_t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);

        // Flags from requester 1
        q.push_back(mk(1'b1, 32'h8000_0000, 4'b0101));
        req_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, c_ADD);
        q.push_back(mk(1'b1, 32'h0000_0000, 4'b1010));
        req_op(1'b1, 32'd5, 32'd5, c_SUB);

        // Round-robin: last grant was 1, so order is 0,1,0,1
        q.push_back(mk(1'b0, 32'd30,         4'b0000));
        q.push_back(mk(1'b1, 32'h0000_0000,  4'b1010));
        q.push_back(mk(1'b0, 32'hFFFF_FFFE,  4'b0100));
        q.push_back(mk(1'b1, 32'h7FFF_FFFF,  4'b1001));
        fork
            begin
                req_op(1'b0, 32'd10, 32'd20, c_ADD);
                req_op(1'b0, 32'd3,  32'd5,  c_SUB);
            end
            begin
                req_op(1'b1, 32'hFFFF_FFFF, 32'd1, c_ADD);
                req_op(1'b1, 32'h8000_0000, 32'd1, c_SUB);
            end
        join

        // Backpressure
        repeat (4) @(negedge clk);
        bus.rsp_ready = 1'b0;
        q.push_back(mk(1'b0, 32'd300,       4'b0000));
        q.push_back(mk(1'b1, 32'hFFFF_FFFF, 4'b0100));
        req_op(1'b0, 32'd100, 32'd200, c_ADD);
        fork
            req_op(1'b1, 32'd1, 32'd2, c_SUB);
        join_none
        seen = 1'b0;
        for (int n = 0; n < c_LIMIT && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_valid_seen", 64'(seen), 64'd1);
        snap = {bus.rsp_id, bus.rsp_result, bus.rsp_cnzv};
        chk("bp_snapshot", 64'(snap), 64'({1'b0, 32'd300, 4'b0000}));
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_stable",      64'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cnzv}),
                                  64'({1'b1, snap}));
            chk("bp_req1_ready",  64'(bus.req1_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_regrant_req1_ready", 64'(bus.req1_ready), 64'd1);
        wait fork;

        // Random ADD/SUB against the reference model
        for (int i = 0; i < 100; i++) begin
            rid = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i % 10 == 0) ? ra : $urandom;
            rop = ($urandom_range(0, 1) == 0) ? c_ADD : c_SUB;
            q.push_back(ref_op(rid, ra, rb, rop));
            req_op(rid, ra, rb, rop);
        end

        // Fixed priority instance: req0 wins every time while both are valid
        @(negedge clk);
        bus_fp.req0_a = 32'd1; bus_fp.req0_b = 32'd1; bus_fp.req0_op = c_ADD;
        bus_fp.req1_a = 32'd2; bus_fp.req1_b = 32'd2; bus_fp.req1_op = c_ADD;
        bus_fp.req0_valid = 1'b1;
        bus_fp.req1_valid = 1'b1;
        got  = 0;
        seen = 1'b0;
        for (int n = 0; n < c_LIMIT && got < 3; n++) begin
            @(negedge clk);
            #2;
            if (bus_fp.req1_ready) seen = 1'b1;
            if (bus_fp.rsp_valid && bus_fp.rsp_ready) begin
                chk("fp_rsp", 64'({bus_fp.rsp_id, bus_fp.rsp_result}), 64'({1'b0, 32'd2}));
                got++;
            end
        end
        bus_fp.req0_valid = 1'b0;
        bus_fp.req1_valid = 1'b0;
        chk("fp_rsp_count",    64'(got),  64'd3);
        chk("fp_req1_granted", 64'(seen), 64'd0);

        // Drain scoreboard
        for (int n = 0; n < c_LIMIT && q.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
